// File: rtl/xcpt_pkg.sv
// Shared exception codes, privilege constants and sequencer state encoding
// for the exception/return controller and its priority selector.
package xcpt_pkg;

  localparam logic [2:0] XC_ITLB_MISS  = 3'd0;
  localparam logic [2:0] XC_ILLEGAL    = 3'd1;
  localparam logic [2:0] XC_PRIV       = 3'd2;
  localparam logic [2:0] XC_DTLB_MISS  = 3'd3;
  localparam logic [2:0] XC_MISALIGNED = 3'd4;

  // Must stay identical to the register file's privilege encoding.
  localparam logic PRIV_SUPER = 1'b1;
  localparam logic PRIV_USER  = 1'b0;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } xcpt_state_t;

  function automatic logic [2:0] mem_code(input logic kind);
    return kind ? XC_MISALIGNED : XC_DTLB_MISS;
  endfunction

endpackage

// File: rtl/xcpt_ctrl_if.sv
// Bundle of stage requests, register-file capture signals and fetch redirect
// between the pipeline and the exception controller.
interface xcpt_ctrl_if;

  logic        fetch_xcpt_valid;
  logic [31:0] fetch_pc;
  logic        dec_illegal;
  logic        dec_iret;
  logic [31:0] dec_pc;
  logic        mem_xcpt_valid;
  logic        mem_xcpt_kind;
  logic [31:0] mem_pc;
  logic [31:0] mem_addr;
  logic        priv_mode;
  logic [31:0] rm0_data;

  logic        xcpt_valid;
  logic [2:0]  xcpt_type;
  logic [31:0] rmPC;
  logic [31:0] rmAddr;
  logic        iret_instr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  fetch_xcpt_valid, fetch_pc, dec_illegal, dec_iret, dec_pc,
           mem_xcpt_valid, mem_xcpt_kind, mem_pc, mem_addr, priv_mode, rm0_data,
    output xcpt_valid, xcpt_type, rmPC, rmAddr, iret_instr, flush,
           redirect_valid, redirect_pc
  );

  modport master (
    output fetch_xcpt_valid, fetch_pc, dec_illegal, dec_iret, dec_pc,
           mem_xcpt_valid, mem_xcpt_kind, mem_pc, mem_addr, priv_mode, rm0_data,
    input  xcpt_valid, xcpt_type, rmPC, rmAddr, iret_instr, flush,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/xcpt_prio.sv
// Combinational oldest-first selection among the mem, decode and fetch
// exception requests present in the current cycle.
module xcpt_prio
  import xcpt_pkg::*;
(
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_pc,
  input  logic        i_dec_illegal,
  input  logic        i_dec_iret,
  input  logic [31:0] i_dec_pc,
  input  logic        i_mem_valid,
  input  logic        i_mem_kind,
  input  logic [31:0] i_mem_pc,
  input  logic [31:0] i_mem_addr,
  input  logic        i_priv_mode,
  output logic        o_req,
  output logic [2:0]  o_code,
  output logic [31:0] o_pc,
  output logic [31:0] o_addr
);

  logic w_priv_fault;

  // An iret from User mode is itself a privilege violation in decode.
  assign w_priv_fault = i_dec_iret && (i_priv_mode == PRIV_USER);

  always_comb begin
    o_req  = 1'b0;
    o_code = XC_ITLB_MISS;
    o_pc   = 32'd0;
    o_addr = 32'd0;
    if (i_mem_valid) begin
      o_req  = 1'b1;
      o_code = mem_code(i_mem_kind);
      o_pc   = i_mem_pc;
      o_addr = i_mem_addr;
    end else if (i_dec_illegal) begin
      o_req  = 1'b1;
      o_code = XC_ILLEGAL;
      o_pc   = i_dec_pc;
      o_addr = i_dec_pc;
    end else if (w_priv_fault) begin
      o_req  = 1'b1;
      o_code = XC_PRIV;
      o_pc   = i_dec_pc;
      o_addr = i_dec_pc;
    end else if (i_fetch_valid) begin
      o_req  = 1'b1;
      o_code = XC_ITLB_MISS;
      o_pc   = i_fetch_pc;
      o_addr = i_fetch_pc;
    end
  end

endmodule

// File: rtl/xcpt_ctrl.sv
// Exception/iret sequencer: accepts one event from IDLE, strobes the register
// file, holds flush for FLUSH_CYCLES cycles, then issues a one-cycle redirect.
module xcpt_ctrl
  import xcpt_pkg::*;
#(
  parameter logic [31:0] XCPT_VECTOR  = 32'h0000_2000,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic         clock,
  input  logic         reset,
  xcpt_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;

  logic              w_req;
  logic [2:0]        w_code;
  logic [31:0]       w_pc;
  logic [31:0]       w_addr;
  logic              w_iret_ok;

  xcpt_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_xcpt_valid;
  logic [2:0]        r_xcpt_type;
  logic [31:0]       r_rm_pc;
  logic [31:0]       r_rm_addr;
  logic              r_iret_instr;
  logic              r_flush;
  logic              r_redirect_valid;
  logic [31:0]       r_redirect_pc;

  // Assertion clears everything at once; release is retimed onto clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  xcpt_prio u_prio (
    .i_fetch_valid (bus.fetch_xcpt_valid),
    .i_fetch_pc    (bus.fetch_pc),
    .i_dec_illegal (bus.dec_illegal),
    .i_dec_iret    (bus.dec_iret),
    .i_dec_pc      (bus.dec_pc),
    .i_mem_valid   (bus.mem_xcpt_valid),
    .i_mem_kind    (bus.mem_xcpt_kind),
    .i_mem_pc      (bus.mem_pc),
    .i_mem_addr    (bus.mem_addr),
    .i_priv_mode   (bus.priv_mode),
    .o_req         (w_req),
    .o_code        (w_code),
    .o_pc          (w_pc),
    .o_addr        (w_addr)
  );

  // A legal iret yields to any exception seen in the same cycle.
  assign w_iret_ok = bus.dec_iret && (bus.priv_mode == PRIV_SUPER) && !w_req;

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_xcpt_valid     <= 1'b0;
      r_xcpt_type      <= 3'd0;
      r_rm_pc          <= 32'd0;
      r_rm_addr        <= 32'd0;
      r_iret_instr     <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      r_xcpt_valid     <= 1'b0;
      r_iret_instr     <= 1'b0;
      r_redirect_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state       <= ST_FLUSH;
            r_cnt         <= FLUSH_INIT;
            r_xcpt_valid  <= 1'b1;
            r_xcpt_type   <= w_code;
            r_rm_pc       <= w_pc;
            r_rm_addr     <= w_addr;
            r_redirect_pc <= XCPT_VECTOR;
            r_flush       <= 1'b1;
          end else if (w_iret_ok) begin
            r_state       <= ST_FLUSH;
            r_cnt         <= FLUSH_INIT;
            r_iret_instr  <= 1'b1;
            r_redirect_pc <= bus.rm0_data;
            r_flush       <= 1'b1;
          end
        end
        ST_FLUSH: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state          <= ST_REDIRECT;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign bus.xcpt_valid     = r_xcpt_valid;
  assign bus.xcpt_type      = r_xcpt_type;
  assign bus.rmPC           = r_rm_pc;
  assign bus.rmAddr         = r_rm_addr;
  assign bus.iret_instr     = r_iret_instr;
  assign bus.flush          = r_flush;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_xcpt_ctrl.sv
// Bench for xcpt_ctrl: two instances (FLUSH_CYCLES 3 and 1) share one stimulus
// stream and are checked every cycle against an event-timeline reference model.
module tb_xcpt_ctrl;
  import xcpt_pkg::*;

  localparam logic [31:0] VEC = 32'h0000_2000;
  localparam int FC0 = 3;
  localparam int FC1 = 1;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] pc;
    logic [31:0] addr;
  } req_t;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  logic        s_fetch_v, s_ill, s_iret, s_mem_v, s_mem_kind, s_priv;
  logic [31:0] s_fetch_pc, s_dec_pc, s_mem_pc, s_mem_addr, s_rm0;

  int n_vec  = 0;
  int n_miss = 0;
  int n_edge = 0;

  int          fc     [2];
  int          m_acc  [2];
  int          m_kind [2];
  logic [2:0]  m_type [2];
  logic [31:0] m_pc   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_rpc  [2];

  xcpt_ctrl_if if0 ();
  xcpt_ctrl_if if1 ();

  assign if0.fetch_xcpt_valid = s_fetch_v;  assign if1.fetch_xcpt_valid = s_fetch_v;
  assign if0.fetch_pc         = s_fetch_pc; assign if1.fetch_pc         = s_fetch_pc;
  assign if0.dec_illegal      = s_ill;      assign if1.dec_illegal      = s_ill;
  assign if0.dec_iret         = s_iret;     assign if1.dec_iret         = s_iret;
  assign if0.dec_pc           = s_dec_pc;   assign if1.dec_pc           = s_dec_pc;
  assign if0.mem_xcpt_valid   = s_mem_v;    assign if1.mem_xcpt_valid   = s_mem_v;
  assign if0.mem_xcpt_kind    = s_mem_kind; assign if1.mem_xcpt_kind    = s_mem_kind;
  assign if0.mem_pc           = s_mem_pc;   assign if1.mem_pc           = s_mem_pc;
  assign if0.mem_addr         = s_mem_addr; assign if1.mem_addr         = s_mem_addr;
  assign if0.priv_mode        = s_priv;     assign if1.priv_mode        = s_priv;
  assign if0.rm0_data         = s_rm0;      assign if1.rm0_data         = s_rm0;

  xcpt_ctrl #(.XCPT_VECTOR(VEC), .FLUSH_CYCLES(FC0)) u_dut0 (
    .clock(clock), .reset(rst_n), .bus(if0.slave));
  xcpt_ctrl #(.XCPT_VECTOR(VEC), .FLUSH_CYCLES(FC1)) u_dut1 (
    .clock(clock), .reset(rst_n), .bus(if1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_acc[i]  = -1000;
    m_kind[i] = 0;
    m_type[i] = 3'd0;
    m_pc[i]   = 32'd0;
    m_addr[i] = 32'd0;
    m_rpc[i]  = 32'd0;
  endtask

  // Event timeline: accepted at edge A, strobe after A, flush for fc cycles,
  // redirect after edge A+fc, next acceptance no earlier than edge A+fc+2.
  task automatic model_edge(input int i);
    req_t q[$];
    if (!rst_n) begin
      model_reset(i);
    end else if (n_edge >= m_acc[i] + fc[i] + 2) begin
      if (s_mem_v)                 q.push_back('{mem_code(s_mem_kind), s_mem_pc, s_mem_addr});
      if (s_ill)                   q.push_back('{XC_ILLEGAL, s_dec_pc, s_dec_pc});
      if (s_iret && s_priv == 1'b0) q.push_back('{XC_PRIV, s_dec_pc, s_dec_pc});
      if (s_fetch_v)               q.push_back('{XC_ITLB_MISS, s_fetch_pc, s_fetch_pc});
      if (q.size() > 0) begin
        m_acc[i]  = n_edge;
        m_kind[i] = 1;
        m_type[i] = q[0].code;
        m_pc[i]   = q[0].pc;
        m_addr[i] = q[0].addr;
        m_rpc[i]  = VEC;
      end else if (s_iret && s_priv) begin
        m_acc[i]  = n_edge;
        m_kind[i] = 2;
        m_rpc[i]  = s_rm0;
      end
    end
  endtask

  task automatic cmp_dut(input int i, input logic xv, input logic [2:0] xt,
                         input logic [31:0] pc, input logic [31:0] addr,
                         input logic ir, input logic fl, input logic rv,
                         input logic [31:0] rpc);
    int d;
    d = n_edge - m_acc[i];
    check($sformatf("d%0d_xcpt_valid@%0d", i, n_edge), 32'(xv), 32'(d == 0 && m_kind[i] == 1));
    check($sformatf("d%0d_iret_instr@%0d", i, n_edge), 32'(ir), 32'(d == 0 && m_kind[i] == 2));
    check($sformatf("d%0d_flush@%0d", i, n_edge), 32'(fl), 32'(d >= 0 && d < fc[i]));
    check($sformatf("d%0d_redirect_valid@%0d", i, n_edge), 32'(rv), 32'(d == fc[i]));
    check($sformatf("d%0d_xcpt_type@%0d", i, n_edge), 32'(xt), 32'(m_type[i]));
    check($sformatf("d%0d_rmPC@%0d", i, n_edge), pc, m_pc[i]);
    check($sformatf("d%0d_rmAddr@%0d", i, n_edge), addr, m_addr[i]);
    check($sformatf("d%0d_redirect_pc@%0d", i, n_edge), rpc, m_rpc[i]);
  endtask

  task automatic cmp_all();
    cmp_dut(0, if0.xcpt_valid, if0.xcpt_type, if0.rmPC, if0.rmAddr,
            if0.iret_instr, if0.flush, if0.redirect_valid, if0.redirect_pc);
    cmp_dut(1, if1.xcpt_valid, if1.xcpt_type, if1.rmPC, if1.rmAddr,
            if1.iret_instr, if1.flush, if1.redirect_valid, if1.redirect_pc);
  endtask

  task automatic cyc();
    @(posedge clock);
    n_edge++;
    model_edge(0);
    model_edge(1);
    #1;
    cmp_all();
  endtask

  task automatic idle(input int k);
    repeat (k) cyc();
  endtask

  task automatic clr();
    s_fetch_v = 1'b0; s_ill = 1'b0; s_iret = 1'b0; s_mem_v = 1'b0; s_mem_kind = 1'b0;
  endtask

  initial begin
    fc[0] = FC0;
    fc[1] = FC1;
    model_reset(0);
    model_reset(1);
    clr();
    s_priv = 1'b0; s_fetch_pc = 32'd0; s_dec_pc = 32'd0;
    s_mem_pc = 32'd0; s_mem_addr = 32'd0; s_rm0 = 32'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clock);
    idle(2);
    rst_n = 1'b1;
    idle(4);

    // Single DTLB miss
    s_mem_v = 1'b1; s_mem_kind = 1'b0; s_mem_pc = 32'h100; s_mem_addr = 32'hDEAD0;
    cyc();
    clr();
    check("dtlb_xcpt_valid", 32'(if0.xcpt_valid), 32'd1);
    check("dtlb_type", 32'(if0.xcpt_type), 32'd3);
    check("dtlb_rmPC", if0.rmPC, 32'h100);
    check("dtlb_rmAddr", if0.rmAddr, 32'hDEAD0);
    check("dtlb_flush", 32'(if0.flush), 32'd1);
    idle(3);
    check("dtlb_redirect_valid", 32'(if0.redirect_valid), 32'd1);
    check("dtlb_redirect_pc", if0.redirect_pc, 32'h2000);
    check("dtlb_redirect_noflush", 32'(if0.flush), 32'd0);
    idle(6);

    // Simultaneous fetch, decode-illegal and mem; held through the busy window
    s_fetch_v = 1'b1; s_fetch_pc = 32'h300; s_ill = 1'b1; s_dec_pc = 32'h200;
    s_mem_v = 1'b1; s_mem_kind = 1'b0; s_mem_pc = 32'h180; s_mem_addr = 32'hBEEF0;
    cyc();
    check("simul_type", 32'(if0.xcpt_type), 32'd3);
    check("simul_rmPC", if0.rmPC, 32'h180);
    repeat (FC0 + 1) begin
      cyc();
      check("simul_no_rereport", 32'(if0.xcpt_valid), 32'd0);
    end
    clr();
    idle(8);

    // Legal iret in Supervisor mode
    s_iret = 1'b1; s_priv = 1'b1; s_rm0 = 32'h440; s_dec_pc = 32'h600;
    cyc();
    clr();
    check("iret_strobe", 32'(if0.iret_instr), 32'd1);
    check("iret_no_xcpt", 32'(if0.xcpt_valid), 32'd0);
    s_rm0 = 32'h999;
    idle(3);
    check("iret_redirect_pc", if0.redirect_pc, 32'h440);
    idle(4);

    // iret from User mode is a privilege exception
    s_iret = 1'b1; s_priv = 1'b0; s_dec_pc = 32'h880;
    cyc();
    clr();
    check("priv_type", 32'(if0.xcpt_type), 32'd2);
    check("priv_rmPC", if0.rmPC, 32'h880);
    idle(6);

    // Legal iret loses to a same-cycle misaligned access
    s_iret = 1'b1; s_priv = 1'b1; s_mem_v = 1'b1; s_mem_kind = 1'b1;
    s_mem_pc = 32'h1C0; s_mem_addr = 32'h1003;
    cyc();
    clr();
    check("iret_loses_type", 32'(if0.xcpt_type), 32'd4);
    check("iret_loses_no_iret", 32'(if0.iret_instr), 32'd0);
    idle(6);

    // Requests held continuously
    s_ill = 1'b1;
    for (int k = 0; k < 30; k++) begin
      s_dec_pc = $urandom;
      s_priv   = 1'($urandom_range(0, 1));
      cyc();
    end
    clr();
    idle(6);

    // Reset during the second flush cycle
    s_fetch_v = 1'b1; s_fetch_pc = 32'h7000;
    cyc();
    clr();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check("rst_mid_flush", 32'(if0.flush), 32'd0);
    check("rst_mid_rmPC", if0.rmPC, 32'd0);
    cmp_all();
    idle(2);
    rst_n = 1'b1;
    idle(6);
    s_fetch_v = 1'b1; s_fetch_pc = 32'h7400;
    cyc();
    clr();
    check("post_rst_type", 32'(if0.xcpt_type), 32'd0);
    check("post_rst_rmPC", if0.rmPC, 32'h7400);
    idle(6);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      s_mem_v    = ($urandom_range(0, 7) == 0);
      s_mem_kind = 1'($urandom_range(0, 1));
      s_ill      = ($urandom_range(0, 9) == 0);
      s_iret     = ($urandom_range(0, 5) == 0);
      s_fetch_v  = ($urandom_range(0, 7) == 0);
      s_priv     = 1'($urandom_range(0, 1));
      s_fetch_pc = $urandom; s_dec_pc = $urandom; s_mem_pc = $urandom;
      s_mem_addr = $urandom; s_rm0 = $urandom;
      cyc();
    end
    clr();
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/xcpt_ctrl.md
# xcpt_ctrl

Exception and return sequencer for the custom core. It collects exception requests from the fetch, decode and memory stages and picks the oldest one. It then drives the capture interface of the register file (xcpt_valid, xcpt_type, rmPC, rmAddr, iret_instr), flushes the pipeline and redirects fetch. Redirection goes to the handler vector on an exception, or to the saved return PC on iret.

## Interface
Parameters:
- XCPT_VECTOR, 32'h0000_2000, handler entry PC driven on redirect after an exception.
- FLUSH_CYCLES, 3, number of cycles flush stays asserted (legal range 1..15).

Ports:
- clock  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; state cleared immediately on assertion, released synchronously to clock.
- fetch_xcpt_valid  in  1  instruction TLB miss at fetch.
- fetch_pc  in  32  PC of the faulting fetch.
- dec_illegal  in  1  illegal opcode in decode.
- dec_iret  in  1  decode holds an iret instruction.
- dec_pc  in  32  PC of the decode-stage instruction.
- mem_xcpt_valid  in  1  memory-stage exception.
- mem_xcpt_kind  in  1  0 = DTLB miss, 1 = misaligned access.
- mem_pc  in  32  PC of the memory-stage instruction.
- mem_addr  in  32  faulting data address.
- priv_mode  in  1  current privilege from the register file (1 = Supervisor).
- rm0_data  in  32  saved return PC from the register file.
- xcpt_valid  out  1  single-cycle capture strobe to the register file.
- xcpt_type  out  3  exception code.
- rmPC  out  32  PC to save.
- rmAddr  out  32  address to save.
- iret_instr  out  1  single-cycle return strobe to the register file.
- flush  out  1  kill all pipeline stages.
- redirect_valid  out  1  single-cycle fetch redirect.
- redirect_pc  out  32  redirect target.

## Operation
- Exception codes: ITLB_MISS = 0, ILLEGAL = 1, PRIV = 2, DTLB_MISS = 3, MISALIGNED = 4.
- Priority among requests sampled in the same cycle, oldest first:
  1. mem (code 3 or 4; rmPC = mem_pc, rmAddr = mem_addr)
  2. dec_illegal (code 1; rmPC = rmAddr = dec_pc)
  3. dec_iret with priv_mode = User (code 2; rmPC = rmAddr = dec_pc)
  4. fetch (code 0; rmPC = rmAddr = fetch_pc)
- A legal iret is dec_iret with priv_mode = Supervisor. It is accepted only when no exception request is present in the same cycle; any exception wins over it.
- States:
  - IDLE: requests are sampled here only.
  - FLUSH: a counter runs from FLUSH_CYCLES down to 1.
  - REDIRECT: one cycle, then back to IDLE.
- Transitions:
  - IDLE + exception → FLUSH. Type, rmPC and rmAddr are registered. Redirect target is set to XCPT_VECTOR.
  - IDLE + legal iret → FLUSH. Redirect target is set to rm0_data as sampled on the acceptance edge.
  - FLUSH with counter = 1 → REDIRECT.
- Requests arriving in FLUSH or REDIRECT are ignored. The pipeline is flushed, so any such request belongs to killed instructions.
- Nested exceptions, taken while already in Supervisor mode, are accepted normally. The register file overwrites its saved state.

## Timing
- Reset values: state = IDLE, counter = 0. All 1-bit outputs are 0; xcpt_type = 0; rmPC, rmAddr and redirect_pc are 0.
- Request sampled on edge T. On edge T+1 the block outputs the following, all registered:
  - xcpt_valid or iret_instr = 1 for exactly one cycle.
  - xcpt_type, rmPC and rmAddr valid; they hold until the next acceptance.
  - flush = 1.
- flush stays high for FLUSH_CYCLES cycles, T+1 through T+FLUSH_CYCLES.
- redirect_valid = 1 with redirect_pc valid in cycle T+FLUSH_CYCLES+1; flush = 0 in that cycle.
- Next request is sampled at edge T+FLUSH_CYCLES+2. Back-to-back events are spaced FLUSH_CYCLES+2 cycles apart.
- xcpt_valid and iret_instr are never high in the same cycle.
- Reset asserted mid-sequence: the block returns to IDLE at once. No strobe or redirect is issued afterwards.

## Structure
- Shared package xcpt_pkg holds:
  - the 3-bit exception code localparams;
  - the Supervisor/User privilege constants, which must match the register file;
  - the state encoding IDLE/FLUSH/REDIRECT.
- One sub-module, xcpt_prio: a combinational priority select producing req, code, pc and addr. The sequencer, registers and counter live in xcpt_ctrl.

## Test plan
- Single DTLB miss (mem_xcpt_kind = 0, mem_pc = 32'h100, mem_addr = 32'hDEAD0) → next cycle: xcpt_valid = 1, type = 3, rmPC = 32'h100, rmAddr = 32'hDEAD0. flush = 1 for 3 cycles, then redirect_pc = 32'h2000.
- Simultaneous fetch, dec_illegal and mem requests → type = 3 from mem. The other requests are not re-reported during FLUSH.
- dec_iret with priv_mode = 1 and rm0_data = 32'h440 → iret_instr pulse, xcpt_valid = 0, redirect_pc = 32'h440. dec_iret with priv_mode = 0 → type = 2, rmPC = dec_pc.
- Exception requests held high continuously → strobes spaced exactly FLUSH_CYCLES+2 cycles apart. Repeat with FLUSH_CYCLES = 1.
- Reset asserted in the second FLUSH cycle → all outputs 0 immediately, no redirect afterward. A new request after release is handled normally.
